// File: rtl/pipe_ctrl.sv
// Pipeline control for the N-stage core: stall resolution, registered flush/redirect,
// stall watchdog and saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int NSTAGE  = 6,
   parameter int AW      = 32,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq_i,
   input  logic              flush_req_i,
   input  logic [AW-1:0]     flush_pc_i,
   input  logic              wd_clr_i,
   input  logic              cnt_clr_i,
   output logic [NSTAGE-1:0] stall_o,
   output logic              flush_o,
   output logic [AW-1:0]     new_pc_o,
   output logic              timeout_o,
   output logic [CW-1:0]     stall_cycles_o
);

   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX = '1;

   logic [NSTAGE-1:0] stall_resolved;
   logic [WDW-1:0]    wd_cnt;
   logic              stalled;

   // A request from stage k freezes every stage upstream of it (suffix OR).
   always_comb begin
      logic acc;
      acc = 1'b0;
      stall_resolved = '0;
      for (int j = NSTAGE - 1; j >= 0; j--) begin
         acc = acc | stallreq_i[j];
         stall_resolved[j] = acc;
      end
   end

   // A flush in progress overrides all stalls, and the vector is forced low in reset.
   always_comb begin
      stall_o = '0;
      if (rst && !flush_o) begin
         stall_o = stall_resolved;
      end
   end

   assign stalled = stall_o[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_o  <= 1'b0;
         new_pc_o <= '0;
      end else begin
         flush_o <= flush_req_i;
         if (flush_req_i) begin
            new_pc_o <= flush_pc_i;
         end
      end
   end

   // The clear takes priority over a trip landing on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt    <= '0;
         timeout_o <= 1'b0;
      end else if (wd_clr_i) begin
         wd_cnt    <= '0;
         timeout_o <= 1'b0;
      end else if (stalled) begin
         if (wd_cnt == WD_LAST) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end else begin
         wd_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_o <= '0;
      end else if (cnt_clr_i) begin
         stall_cycles_o <= '0;
      end else if (stalled && stall_cycles_o != CNT_MAX) begin
         stall_cycles_o <= stall_cycles_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (NSTAGE=6, TIMEOUT=8, CW=4).
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  stallreq_i;
   logic        flush_req_i;
   logic [31:0] flush_pc_i;
   logic        wd_clr_i;
   logic        cnt_clr_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        timeout_o;
   logic [3:0]  stall_cycles_o;

   int errors = 0;
   int checks = 0;

   pipe_ctrl #(.NSTAGE(6), .AW(32), .TIMEOUT(8), .CW(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_i     (stallreq_i),
      .flush_req_i    (flush_req_i),
      .flush_pc_i     (flush_pc_i),
      .wd_clr_i       (wd_clr_i),
      .cnt_clr_i      (cnt_clr_i),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o),
      .timeout_o      (timeout_o),
      .stall_cycles_o (stall_cycles_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, got running want finished");
      $fatal(1, "[TB] time limit");
   end

   // Advance n rising edges, leaving time 1 unit after the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      stallreq_i = 6'b111111;
      flush_req_i = 1'b1;
      flush_pc_i = 32'hDEAD_BEEF;
      wd_clr_i = 1'b0;
      cnt_clr_i = 1'b0;
      step(2);
      checks++; if (stall_o !== 6'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want %b", stall_o, 6'b0); end
      checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b want 0", flush_o); end
      checks++; if (new_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_new_pc: got %h want 0", new_pc_o); end
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o); end
      checks++; if (stall_cycles_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", stall_cycles_o); end
      stallreq_i = 6'b0;
      flush_req_i = 1'b0;
      flush_pc_i = 32'h0;
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_stall_resolve();
      logic [5:0] req_tab [4] = '{6'b000100, 6'b001000, 6'b001100, 6'b000000};
      logic [5:0] exp_tab [4] = '{6'b000111, 6'b001111, 6'b001111, 6'b000000};
      for (int i = 0; i < 4; i++) begin
         stallreq_i = req_tab[i];
         #1;
         checks++;
         if (stall_o !== exp_tab[i]) begin
            errors++;
            $display("[TB] FAIL stall_resolve[%0d]: req %b got %b want %b", i, req_tab[i], stall_o, exp_tab[i]);
         end
      end
      stallreq_i = 6'b100000;
      #1;
      checks++; if (stall_o !== 6'b111111) begin errors++; $display("[TB] FAIL stall_top: got %b want %b", stall_o, 6'b111111); end
      stallreq_i = 6'b0;
      step(1);
   endtask

   task automatic test_flush();
      stallreq_i = 6'b000100;
      flush_req_i = 1'b1;
      flush_pc_i = 32'h0000_0040;
      #1;
      checks++; if (stall_o !== 6'b000111) begin errors++; $display("[TB] FAIL flush_req_cycle_stall: got %b want %b", stall_o, 6'b000111); end
      step(1);
      flush_req_i = 1'b0;
      flush_pc_i = 32'h0;
      #1;
      checks++; if (flush_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_pulse: got %b want 1", flush_o); end
      checks++; if (new_pc_o !== 32'h40) begin errors++; $display("[TB] FAIL flush_new_pc: got %h want 00000040", new_pc_o); end
      checks++; if (stall_o !== 6'b0) begin errors++; $display("[TB] FAIL flush_gates_stall: got %b want %b", stall_o, 6'b0); end
      step(1);
      checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_falls: got %b want 0", flush_o); end
      checks++; if (stall_o !== 6'b000111) begin errors++; $display("[TB] FAIL flush_stall_returns: got %b want %b", stall_o, 6'b000111); end
      checks++; if (new_pc_o !== 32'h40) begin errors++; $display("[TB] FAIL flush_pc_holds: got %h want 00000040", new_pc_o); end
      stallreq_i = 6'b0;
      step(1);
   endtask

   task automatic test_back_to_back();
      flush_req_i = 1'b1;
      flush_pc_i = 32'h0000_0040;
      step(1);
      checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h40) begin errors++; $display("[TB] FAIL b2b_first: got flush=%b pc=%h want flush=1 pc=00000040", flush_o, new_pc_o); end
      flush_pc_i = 32'h0000_0080;
      step(1);
      checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h80) begin errors++; $display("[TB] FAIL b2b_second: got flush=%b pc=%h want flush=1 pc=00000080", flush_o, new_pc_o); end
      flush_req_i = 1'b0;
      flush_pc_i = 32'h0;
      step(1);
      checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h80) begin errors++; $display("[TB] FAIL b2b_end: got flush=%b pc=%h want flush=0 pc=00000080", flush_o, new_pc_o); end
   endtask

   task automatic test_watchdog();
      wd_clr_i = 1'b1;
      cnt_clr_i = 1'b1;
      stallreq_i = 6'b0;
      step(1);
      wd_clr_i = 1'b0;
      cnt_clr_i = 1'b0;
      stallreq_i = 6'b000001;
      step(7);
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL wd_no_trip_7: got %b want 0", timeout_o); end
      stallreq_i = 6'b0;
      step(1);
      stallreq_i = 6'b000001;
      step(7);
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL wd_no_trip_after_gap: got %b want 0", timeout_o); end
      step(1);
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL wd_trip_8: got %b want 1", timeout_o); end
      step(3);
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL wd_sticky: got %b want 1", timeout_o); end
      stallreq_i = 6'b0;
      wd_clr_i = 1'b1;
      step(1);
      wd_clr_i = 1'b0;
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL wd_clear: got %b want 0", timeout_o); end
      // Clear coincident with the trip edge must win.
      stallreq_i = 6'b000001;
      step(7);
      wd_clr_i = 1'b1;
      step(1);
      wd_clr_i = 1'b0;
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL wd_clear_wins: got %b want 0", timeout_o); end
      stallreq_i = 6'b0;
      step(1);
   endtask

   task automatic test_counter();
      cnt_clr_i = 1'b1;
      step(1);
      cnt_clr_i = 1'b0;
      checks++; if (stall_cycles_o !== 4'd0) begin errors++; $display("[TB] FAIL cnt_clear_idle: got %0d want 0", stall_cycles_o); end
      stallreq_i = 6'b010000;
      step(3);
      checks++; if (stall_cycles_o !== 4'd3) begin errors++; $display("[TB] FAIL cnt_three: got %0d want 3", stall_cycles_o); end
      step(17);
      checks++; if (stall_cycles_o !== 4'd15) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d want 15", stall_cycles_o); end
      cnt_clr_i = 1'b1;
      step(1);
      cnt_clr_i = 1'b0;
      checks++; if (stall_cycles_o !== 4'd0) begin errors++; $display("[TB] FAIL cnt_clear_wins: got %0d want 0", stall_cycles_o); end
      stallreq_i = 6'b0;
      step(2);
      checks++; if (stall_cycles_o !== 4'd0) begin errors++; $display("[TB] FAIL cnt_idle_hold: got %0d want 0", stall_cycles_o); end
   endtask

   task automatic test_async_reset();
      wd_clr_i = 1'b1;
      step(1);
      wd_clr_i = 1'b0;
      stallreq_i = 6'b000001;
      step(8);
      stallreq_i = 6'b0;
      flush_req_i = 1'b1;
      flush_pc_i = 32'h0000_0123;
      step(1);
      flush_req_i = 1'b0;
      flush_pc_i = 32'h0;
      checks++; if (flush_o !== 1'b1 || timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL areset_setup: got flush=%b timeout=%b want 1 1", flush_o, timeout_o); end
      stallreq_i = 6'b001000;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL areset_flush: got flush=%b pc=%h want 0 0", flush_o, new_pc_o); end
      checks++; if (timeout_o !== 1'b0 || stall_cycles_o !== 4'd0) begin errors++; $display("[TB] FAIL areset_wd_cnt: got timeout=%b count=%0d want 0 0", timeout_o, stall_cycles_o); end
      checks++; if (stall_o !== 6'b0) begin errors++; $display("[TB] FAIL areset_stall: got %b want %b", stall_o, 6'b0); end
      stallreq_i = 6'b0;
      step(1);
      rst = 1'b1;
      step(1);
      checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0 || timeout_o !== 1'b0 || stall_cycles_o !== 4'd0 || stall_o !== 6'b0) begin
         errors++;
         $display("[TB] FAIL areset_after_release: got flush=%b pc=%h timeout=%b count=%0d stall=%b want all 0", flush_o, new_pc_o, timeout_o, stall_cycles_o, stall_o);
      end
   endtask

   initial begin
      test_reset();
      test_stall_resolve();
      test_flush();
      test_back_to_back();
      test_watchdog();
      test_counter();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
